// File: rtl/bit_serializer_piso_if.sv
// ============================================================================
//  Module   : bit_serializer_piso_if
//  Purpose  : Parallel word handshake in, serial bit stream out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bit_serializer_piso_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             dout_last;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  dout,
        input  dout_valid,
        input  dout_last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output dout,
        output dout_valid,
        output dout_last
    );
endinterface

`default_nettype wire

// File: rtl/bit_serializer_piso.sv
// ============================================================================
//  Module   : bit_serializer_piso
//  Purpose  : PISO serializer with one-word hold register for gapless output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer_piso #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input wire logic             clk,
    input wire logic             rst,
    bit_serializer_piso_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam int         c_HEAD = MSB_FIRST ? WIDTH - 1 : 0;
    localparam logic [4:0] c_LAST = 5'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             dout_q, dout_valid_q, dout_last_q;
    logic             w_accept;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign bus.in_ready   = rst & ~hold_valid_q;
    assign w_accept       = bus.in_valid & bus.in_ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_last  = dout_last_q;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_SHIFT;
                    shreg_d = bus.in_data;
                    cnt_d   = 5'd0;
                end
            end
            S_SHIFT: begin
                if (cnt_q != c_LAST) begin
                    shreg_d = w_shifted;
                    cnt_d   = cnt_q + 5'd1;
                    if (w_accept) begin
                        hold_d       = bus.in_data;
                        hold_valid_d = 1'b1;
                    end
                end else begin
                    // Last bit: held word wins over a bypass word from the bus.
                    cnt_d = 5'd0;
                    if (hold_valid_q) begin
                        shreg_d      = hold_q;
                        hold_valid_d = 1'b0;
                    end else if (w_accept) begin
                        shreg_d = bus.in_data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            cnt_q        <= 5'd0;
            dout_q       <= IDLE_BIT;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            cnt_q        <= cnt_d;
            dout_q       <= (state_d == S_SHIFT) ? shreg_d[c_HEAD] : IDLE_BIT;
            dout_valid_q <= (state_d == S_SHIFT);
            dout_last_q  <= (state_d == S_SHIFT) && (cnt_d == c_LAST);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bit_serializer_piso.sv
// ============================================================================
//  Module   : tb_bit_serializer_piso
//  Purpose  : Scoreboard bench for two serializer configurations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serializer_piso;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_serializer_piso_if #(.WIDTH(8)) a_if ();
    bit_serializer_piso_if #(.WIDTH(4)) b_if ();

    bit_serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    bit_serializer_piso #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    typedef struct packed {
        logic bit_v;
        logic last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   acc_a = 0;
    int   acc_b = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Outputs seen now reflect earlier edges, so compare before pushing the next accept.
    always @(negedge clk) begin : p_mon_a
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check_eq("a_valid", a_if.dout_valid, 1);
            check_eq("a_dout",  a_if.dout, e.bit_v);
            check_eq("a_last",  a_if.dout_last, e.last);
        end else begin
            check_eq("a_idle_valid", a_if.dout_valid, 0);
            check_eq("a_idle_dout",  a_if.dout, 0);
            check_eq("a_idle_last",  a_if.dout_last, 0);
        end
        if (!rst) begin
            qa.delete();
        end else if (a_if.in_valid && a_if.in_ready) begin
            acc_a++;
            for (int i = 0; i < 8; i++)
                qa.push_back('{bit_v: a_if.in_data[7-i], last: (i == 7)});
        end
    end

    always @(negedge clk) begin : p_mon_b
        exp_t e;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check_eq("b_valid", b_if.dout_valid, 1);
            check_eq("b_dout",  b_if.dout, e.bit_v);
            check_eq("b_last",  b_if.dout_last, e.last);
        end else begin
            check_eq("b_idle_valid", b_if.dout_valid, 0);
            check_eq("b_idle_dout",  b_if.dout, 1);
            check_eq("b_idle_last",  b_if.dout_last, 0);
        end
        if (!rst) begin
            qb.delete();
        end else if (b_if.in_valid && b_if.in_ready) begin
            acc_b++;
            for (int i = 0; i < 4; i++)
                qb.push_back('{bit_v: b_if.in_data[i], last: (i == 3)});
        end
    end

    task automatic send_a(input logic [7:0] w);
        int n;
        a_if.in_data  = w;
        a_if.in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (a_if.in_ready) break;
            n++;
            if (n > 50) begin
                check_eq("send_a_timeout", a_if.in_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        a_if.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] w);
        int n;
        b_if.in_data  = w;
        b_if.in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (b_if.in_ready) break;
            n++;
            if (n > 50) begin
                check_eq("send_b_timeout", b_if.in_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        b_if.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b0;
        a_if.in_data  = 8'hB0;
        a_if.in_valid = 1'b1;
        b_if.in_data  = 4'b1101;
        b_if.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_ready_a", a_if.in_ready, 0);
            check_eq("rst_ready_b", b_if.in_ready, 0);
        end
        @(posedge clk);
        #1;
        rst           = 1'b1;
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
        check_eq("rst_no_accept", acc_a + acc_b, 0);
        repeat (2) @(posedge clk);
        #1;

        // Single word.
        send_a(8'hB0);
        repeat (12) @(posedge clk);
        #1;

        // Back-to-back with a third word pressing against a full hold register.
        a_if.in_data  = 8'hB0;
        a_if.in_valid = 1'b1;
        @(negedge clk);
        check_eq("b2b_ready1", a_if.in_ready, 1);
        @(posedge clk);
        #1;
        a_if.in_data = 8'h0B;
        @(negedge clk);
        check_eq("b2b_ready2", a_if.in_ready, 1);
        @(posedge clk);
        #1;
        a_if.in_data = 8'h55;
        repeat (7) begin
            @(negedge clk);
            check_eq("hold_full_ready", a_if.in_ready, 0);
        end
        check_eq("hold_refuse_acc", acc_a, 3);
        @(negedge clk);
        check_eq("hold_free_ready", a_if.in_ready, 1);
        @(posedge clk);
        #1;
        a_if.in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        // Bypass: next word offered only during the last-bit cycle.
        send_a(8'hA5);
        repeat (7) @(posedge clk);
        #1;
        a_if.in_data  = 8'hFF;
        a_if.in_valid = 1'b1;
        @(negedge clk);
        check_eq("bypass_last",  a_if.dout_last, 1);
        check_eq("bypass_ready", a_if.in_ready, 1);
        @(posedge clk);
        #1;
        a_if.in_valid = 1'b0;
        check_eq("bypass_acc", acc_a, 6);
        repeat (12) @(posedge clk);
        #1;

        // Reset after three bits with a word held.
        send_a(8'hB0);
        a_if.in_data  = 8'h0B;
        a_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_if.in_valid = 1'b0;
        check_eq("mid_acc", acc_a, 8);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ready", a_if.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_idle", a_if.dout_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        send_a(8'hAA);
        repeat (12) @(posedge clk);
        #1;

        // Narrow, LSB-first, idle-high configuration.
        send_b(4'b1101);
        repeat (8) @(posedge clk);
        #1;
        check_eq("b_acc", acc_b, 1);

        check_eq("a_drained", qa.size(), 0);
        check_eq("b_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
